// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs into an external MAC cell,
// captures the finished accumulator, then clears the MAC for the next vector.
module mac_dot_seq #(
  parameter int Q     = 10,
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             mac_en,
  output logic [N-1:0]     mac_a,
  output logic [N-1:0]     mac_b,
  output logic             mac_clr,
  input  logic [N-1:0]     mac_out,
  input  logic             mac_ovr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_ovr,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);

  // Q is only meaningful to the MAC; reject configurations it cannot represent.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("mac_dot_seq: Q must lie in [0, N-1]");
  end

  typedef enum logic [1:0] {RUN, DRAIN, CAPTURE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic             accept, cap_fire;
  logic [CNT_W-1:0] cnt;
  logic             sticky;

  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;
  assign cap_fire = (state == CAPTURE) && (!res_valid || res_ready);
  assign busy     = (state != RUN) || mac_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = CAPTURE;
      CAPTURE: if (cap_fire) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // mac_en mirrors acceptance: it is only ever high for the cycle after an
  // accept, which also covers the DRAIN cycle for the last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clr   <= 1'b1;
      cnt       <= '0;
      sticky    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovr   <= 1'b0;
      res_count <= '0;
    end else begin
      mac_en <= accept;
      if (accept) begin
        mac_a <= in_a;
        mac_b <= in_b;
        if (!(&cnt)) cnt <= cnt + 1'b1;
      end
      if (state == CLEAR) begin
        mac_clr <= 1'b0;
        cnt     <= '0;
        sticky  <= 1'b0;
      end else if (mac_en && mac_ovr) begin
        sticky <= 1'b1;
      end
      // A new capture wins over a same-edge consumer handshake.
      if (cap_fire) begin
        res_data  <= mac_out;
        res_ovr   <= sticky;
        res_count <= cnt;
        res_valid <= 1'b1;
        mac_clr   <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
